// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit channel between NUM_REQ requesters,
// with packet-atomic locking and a watchdog for a UART that never goes busy.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [NUM_REQ*9-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic                   o_tx_valid,
    output logic [8:0]             o_tx_parallel,
    input  logic                   i_tx_ready,
    output logic [ID_W-1:0]        o_grant_id,
    output logic                   o_busy,
    output logic                   o_error,
    input  logic                   i_err_clr
);

    localparam int               CNT_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t             state_r,    state_s;
    logic               lock_r,     lock_s;
    logic [ID_W-1:0]    rr_ptr_r,   rr_ptr_s;
    logic [CNT_W-1:0]   cnt_r,      cnt_s;
    logic [8:0]         data_r,     data_s;
    logic [ID_W-1:0]    id_r,       id_s;
    logic               tx_valid_r, tx_valid_s;
    logic               busy_r,     busy_s;
    logic               err_r,      err_s;

    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] grant_s;
    logic               win_found_s;
    logic [ID_W-1:0]    win_id_s;
    logic [ID_W-1:0]    cand_s;
    logic               timeout_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic [8:0]         req_word_s [NUM_REQ];

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        logic [ID_W-1:0] nxt;
        if (id == LAST_ID) begin
            nxt = '0;
        end else begin
            nxt = id + ID_W'(1);
        end
        return nxt;
    endfunction

    // Unpack the flat requester data bus into one word per requester
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_word_s[k] = i_req_data[k*9 +: 9];
        end
    end

    // While a packet is locked only its owner may compete
    always_comb begin
        if (lock_r) begin
            eligible_s = i_req_valid & (NUM_REQ'(1) << id_r);
        end else begin
            eligible_s = i_req_valid;
        end
    end

    // Round-robin search beginning at rr_ptr_r
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = '0;
        cand_s      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = ID_W'((int'(rr_ptr_r) + i) % NUM_REQ);
            if (!win_found_s && eligible_s[cand_s]) begin
                win_found_s = 1'b1;
                win_id_s    = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Accept strobe is combinational and held low throughout reset
    always_comb begin
        if (i_rst_n && (state_r == S_IDLE) && i_tx_ready && win_found_s) begin
            grant_s = NUM_REQ'(1) << win_id_s;
        end else begin
            grant_s = '0;
        end
    end

    assign o_req_ready = grant_s;
    assign cnt_inc_s   = cnt_r + CNT_W'(1);

    // Next-state, lock, pointer, watchdog and output computation
    always_comb begin
        state_s    = state_r;
        lock_s     = lock_r;
        rr_ptr_s   = rr_ptr_r;
        cnt_s      = cnt_r;
        data_s     = data_r;
        id_s       = id_r;
        tx_valid_s = 1'b0;
        timeout_s  = 1'b0;
        err_s      = err_r;
        busy_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (grant_s != '0) begin
                    data_s     = req_word_s[win_id_s];
                    id_s       = win_id_s;
                    tx_valid_s = 1'b1;
                    state_s    = S_ISSUE;
                    if (i_req_last[win_id_s]) begin
                        lock_s   = 1'b0;
                        rr_ptr_s = wrap_inc(win_id_s);
                    end else begin
                        lock_s   = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_s   = '0;
                state_s = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!i_tx_ready) begin
                    state_s = S_WAIT_DONE;
                end else if (cnt_inc_s == CNT_MAX) begin
                    // UART never started: give up on this word and the packet lock
                    cnt_s     = cnt_inc_s;
                    timeout_s = 1'b1;
                    lock_s    = 1'b0;
                    rr_ptr_s  = wrap_inc(id_r);
                    state_s   = S_IDLE;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            S_WAIT_DONE: begin
                if (i_tx_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_WAIT_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        if (timeout_s) begin
            err_s = 1'b1;
        end else if (i_err_clr) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end

        busy_s = (state_s != S_IDLE) || lock_s;
    end

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= S_IDLE;
            lock_r     <= 1'b0;
            rr_ptr_r   <= '0;
            cnt_r      <= '0;
            data_r     <= 9'd0;
            id_r       <= '0;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            lock_r     <= lock_s;
            rr_ptr_r   <= rr_ptr_s;
            cnt_r      <= cnt_s;
            data_r     <= data_s;
            id_r       <= id_s;
            tx_valid_r <= tx_valid_s;
            busy_r     <= busy_s;
            err_r      <= err_s;
        end
    end

    assign o_tx_valid    = tx_valid_r;
    assign o_tx_parallel = data_r;
    assign o_grant_id    = id_r;
    assign o_busy        = busy_r;
    assign o_error       = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: a packet-level round-robin model
// predicts the issued word order; a monitor checks every tx pulse against it.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic [N-1:0]     req_valid;
    logic [N*9-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             tx_valid;
    logic [8:0]       tx_par;
    logic             tx_ready;
    logic [1:0]       grant_id;
    logic             busy;
    logic             err;
    logic             err_clr = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TO)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_req_valid   (req_valid),
        .i_req_data    (req_data),
        .i_req_last    (req_last),
        .o_req_ready   (req_ready),
        .o_tx_valid    (tx_valid),
        .o_tx_parallel (tx_par),
        .i_tx_ready    (tx_ready),
        .o_grant_id    (grant_id),
        .o_busy        (busy),
        .o_error       (err),
        .i_err_clr     (err_clr)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [9:0]  dq [N][$];   // words still to be offered by each requester {last,data}
    logic [9:0]  mq [N][$];   // words the reference model has not yet scheduled
    logic [10:0] exp_q [$];   // expected issue order {id,data}
    int          model_ptr = 0;
    int          gap [N];
    bit          wd_mode  = 1'b0;
    bit          stall_en = 1'b0;
    int          err_rises = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check_eq(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic add_word(input int k, input logic [8:0] d, input bit last,
                            input bit to_drv, input bit to_model);
        if (to_drv)   dq[k].push_back({last, d});
        if (to_model) mq[k].push_back({last, d});
    endtask

    // Packet-level round robin: the first requester at or after the pointer with
    // pending words sends its whole packet, then the pointer moves past it.
    task automatic model_run();
        bit any;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int i = 0; i < N && !any; i++) begin
                int k;
                k = (model_ptr + i) % N;
                if (mq[k].size() > 0) begin
                    logic [9:0] w;
                    logic [1:0] kid;
                    any = 1'b1;
                    kid = k[1:0];
                    do begin
                        w = mq[k].pop_front();
                        exp_q.push_back({kid, w[8:0]});
                    end while (!w[9] && mq[k].size() > 0);
                    model_ptr = (k + 1) % N;
                end
            end
        end
    endtask

    function automatic bit drv_empty();
        bit e;
        e = 1'b1;
        for (int k = 0; k < N; k++) if (dq[k].size() > 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_drain(input string nm);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge i_clk);
            n++;
            done = (exp_q.size() == 0) && !busy && drv_empty();
        end
        check_eq({"drain_", nm}, int'(done), 1);
        repeat (2) @(negedge i_clk);
    endtask

    // Requester drivers: offer the head of each queue, pop on accept
    initial begin
        logic [N-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int k = 0; k < N; k++) gap[k] = 0;
        forever begin
            @(negedge i_clk);
            acc = req_ready & req_valid;
            @(posedge i_clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc[k] && dq[k].size() > 0) begin
                    if (!dq[k][0][9]) gap[k] = int'($urandom_range(0, 2));
                    void'(dq[k].pop_front());
                end
                if (gap[k] > 0) begin
                    req_valid[k] = 1'b0;
                    gap[k]--;
                end else if (dq[k].size() > 0) begin
                    req_valid[k]         = 1'b1;
                    req_data[k*9 +: 9]   = dq[k][0][8:0];
                    req_last[k]          = dq[k][0][9];
                end else begin
                    req_valid[k] = 1'b0;
                    req_last[k]  = 1'b0;
                end
            end
        end
    end

    // UART model: after a tx pulse optionally stays ready a few cycles, then busy
    initial begin
        int  ust;
        int  dly;
        int  bsy;
        bit  saw;
        ust = 0;
        dly = 0;
        bsy = 0;
        tx_ready = 1'b1;
        forever begin
            @(negedge i_clk);
            saw = tx_valid;
            @(posedge i_clk);
            #1;
            if (!i_rst_n) begin
                ust = 0;
                tx_ready = 1'b1;
            end else begin
                case (ust)
                    0: begin
                        if (saw && !wd_mode) begin
                            dly = int'($urandom_range(0, 3));
                            bsy = int'($urandom_range(1, 6));
                            if (dly == 0) begin
                                tx_ready = 1'b0;
                                ust = 2;
                            end else begin
                                tx_ready = 1'b1;
                                ust = 1;
                            end
                        end else if (!saw && stall_en && ($urandom_range(0, 7) == 0)) begin
                            tx_ready = 1'b0;
                        end else begin
                            tx_ready = 1'b1;
                        end
                    end
                    1: begin
                        dly--;
                        if (dly == 0) begin
                            tx_ready = 1'b0;
                            ust = 2;
                        end
                    end
                    2: begin
                        bsy--;
                        if (bsy == 0) begin
                            tx_ready = 1'b1;
                            ust = 0;
                        end
                    end
                    default: ust = 0;
                endcase
            end
        end
    end

    // Monitor: compares every issued word and checks handshake timing
    initial begin
        bit         prev_acc;
        bit         prev_err;
        int         last_tv;
        logic [10:0] e;
        prev_acc = 1'b0;
        prev_err = 1'b0;
        last_tv  = -100;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                check_eq("rst_ready", int'(req_ready), 0);
                check_eq("rst_outputs", int'({tx_valid, tx_par, grant_id, busy, err}), 0);
                prev_acc = 1'b0;
                prev_err = 1'b0;
            end else begin
                if (req_ready != '0)
                    check_eq("ready_legal",
                             int'($onehot(req_ready) && ((req_ready & ~req_valid) == '0)
                                  && tx_ready && !prev_acc), 1);
                if (tx_valid || prev_acc)
                    check_eq("tx_valid_latency", int'(tx_valid), int'(prev_acc));
                if (tx_valid) begin
                    last_tv = cyc;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: got id=%0d data=0x%0h, expected none", grant_id, tx_par);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("tx_data", int'(tx_par), int'(e[8:0]));
                        check_eq("grant_id", int'(grant_id), int'(e[10:9]));
                    end
                end
                if (err && !prev_err) begin
                    err_rises++;
                    check_eq("error_only_on_timeout", int'(wd_mode), 1);
                    check_eq("watchdog_delay", cyc - last_tv, TO + 1);
                end
                prev_acc = (req_ready != '0);
                prev_err = err;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    // Phase sequencing
    initial begin
        logic [8:0] d;
        int         np;
        int         len;
        @(posedge i_clk);
        #2;
        // Fairness words are offered already during reset
        add_word(0, 9'h010, 1'b1, 1'b1, 1'b1);
        add_word(1, 9'h011, 1'b1, 1'b1, 1'b1);
        add_word(2, 9'h012, 1'b1, 1'b1, 1'b1);
        add_word(3, 9'h013, 1'b1, 1'b1, 1'b1);
        add_word(0, 9'h010, 1'b1, 1'b1, 1'b1);
        add_word(1, 9'h011, 1'b1, 1'b1, 1'b1);
        model_run();
        repeat (25) @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_eq("post_rst_outputs", int'({tx_valid, tx_par, grant_id, busy, err}), 0);
        wait_drain("fairness");

        // Atomic packet from req2 while req1 waits
        @(posedge i_clk);
        #2;
        add_word(2, 9'h011, 1'b0, 1'b1, 1'b1);
        add_word(2, 9'h022, 1'b0, 1'b1, 1'b1);
        add_word(2, 9'h033, 1'b1, 1'b1, 1'b1);
        add_word(1, 9'h1C1, 1'b1, 1'b1, 1'b1);
        model_run();
        wait_drain("atomic");

        // Single word
        @(posedge i_clk);
        #2;
        add_word(0, 9'h0A5, 1'b1, 1'b1, 1'b1);
        model_run();
        wait_drain("single");
        check_eq("single_held_data", int'(tx_par), 'h0A5);
        check_eq("single_grant_id", int'(grant_id), 0);

        // Randomized packets with UART stalls
        stall_en = 1'b1;
        for (int r = 0; r < 25; r++) begin
            @(posedge i_clk);
            #2;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    np = int'($urandom_range(1, 2));
                    for (int p = 0; p < np; p++) begin
                        len = int'($urandom_range(1, 3));
                        for (int w = 0; w < len; w++) begin
                            d = 9'($urandom);
                            add_word(k, d, (w == len - 1), 1'b1, 1'b1);
                        end
                    end
                end
            end
            model_run();
            wait_drain("random");
        end
        stall_en = 1'b0;

        // Watchdog: UART never drops ready
        wd_mode = 1'b1;
        @(posedge i_clk);
        #2;
        add_word(1, 9'h0B1, 1'b1, 1'b1, 1'b1);
        add_word(2, 9'h0B2, 1'b1, 1'b1, 1'b1);
        model_run();
        wait_drain("watchdog");
        check_eq("error_sticky", int'(err), 1);
        check_eq("error_rise_count", err_rises, 1);
        @(posedge i_clk);
        #2;
        err_clr = 1'b1;
        @(posedge i_clk);
        #2;
        err_clr = 1'b0;
        @(negedge i_clk);
        check_eq("error_cleared", int'(err), 0);
        wd_mode = 1'b0;

        // Reset during WAIT_DONE of req3's first (non-last) word
        @(posedge i_clk);
        #2;
        add_word(3, 9'h1F3, 1'b0, 1'b1, 1'b0);
        add_word(3, 9'h1E3, 1'b1, 1'b1, 1'b0);
        exp_q.push_back({2'd3, 9'h1F3});
        begin
            int n;
            n = 0;
            while (!(exp_q.size() == 0 && !tx_ready) && n < 200) begin
                @(negedge i_clk);
                n++;
            end
            check_eq("midburst_reach_busy", int'(n < 200), 1);
        end
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        exp_q.delete();
        for (int k = 0; k < N; k++) mq[k].delete();
        model_ptr = 0;
        add_word(3, 9'h1E3, 1'b1, 1'b0, 1'b1);
        add_word(0, 9'h0C0, 1'b1, 1'b1, 1'b1);
        model_run();
        repeat (3) @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_eq("midburst_busy_cleared", int'(busy), 0);
        check_eq("midburst_grant_reset", int'(grant_id), 0);
        wait_drain("midburst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
